// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the 32 x 8 instruction memory
// Accepts count, instruction bytes and checksum; holds the CPU in reset until the image verifies.
module prog_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_din_o,
  output logic                  cpu_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DATA_WIDTH:0] DEPTH_C = (DATA_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdin_q, wdin_d;

  logic                  loading;
  logic                  xfer;
  logic [TW-1:0]         tmo_nxt;
  logic [DATA_WIDTH-1:0] chk_sum;

  assign loading = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign xfer    = in_valid_i && loading;
  assign tmo_nxt = tmo_q + 1'b1;
  assign chk_sum = sum_q + in_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdin_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdin_q  <= wdin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdin_d  = wdin_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_COUNT;
          tmo_d   = '0;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          if (in_data_i != '0 && {1'b0, in_data_i} <= DEPTH_C) begin
            state_d = S_DATA;
            rem_d   = in_data_i[ADDR_WIDTH:0];
            addr_d  = '0;
            sum_d   = in_data_i;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdin_d  = in_data_i;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          sum_d   = chk_sum;
          if (rem_q == (ADDR_WIDTH + 1)'(1)) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (chk_sum == '0) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Any accepted byte restarts the idle window; a stall that reaches TIMEOUT aborts.
    if (loading) begin
      if (xfer) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_nxt;
        if (tmo_nxt == TIMEOUT_C) state_d = S_ERR;
      end
    end
  end

  assign in_ready_o = loading;
  assign busy_o     = loading;
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERR);
  assign cpu_rst_o  = (state_q != S_DONE);
  assign mem_en_o   = we_q;
  assign mem_we_o   = we_q;
  assign mem_addr_o = waddr_q;
  assign mem_din_o  = wdin_q;

endmodule
